// File: rtl/missile_pool_pkg.sv
// Shared constants, FSM state type and small helpers for the invader missile pool.
package missile_pool_pkg;

  // Playfield geometry shared with the invader grid and the VGA side.
  localparam int GRID_COLS = 11;
  localparam int GRID_ROWS = 5;
  localparam int COL_PITCH = 16;
  localparam int ROW_PITCH = 16;
  localparam int SCREEN_H  = 480;

  // Spawn sequencer states; the encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    SPAWN  = 2'd2
  } fsm_t;

  // Fold a 4-bit random value into a column index with one conditional subtract.
  function automatic int lfsr_col(input logic [3:0] v, input int cols);
    int c;
    c = int'(v);
    if (c >= cols) c = c - cols;
    return c;
  endfunction

endpackage

// File: rtl/missile_pool_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping every clock.
// load reloads the seed synchronously (used for a game restart).
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] q;

  // Shift left, feeding back the XOR of the polynomial taps into bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

  assign out = q;

endmodule

// File: rtl/missile_pool.sv
// Pool of N invader missiles: periodic random-column spawning from the
// bottom-most live invader, per-frame descent, and retirement on player hit
// or screen bottom. Interface timing: frame and player_collision are sampled
// on the rising edge; fire is a single-cycle pulse in the cycle the slot loads.
module missile_pool #(
  parameter int         N_MISSILES   = 3,
  parameter int         SPEED        = 2,
  parameter int         SPAWN_FRAMES = 30,
  parameter int         GRID_COLS    = missile_pool_pkg::GRID_COLS,
  parameter int         GRID_ROWS    = missile_pool_pkg::GRID_ROWS,
  parameter int         COL_PITCH    = missile_pool_pkg::COL_PITCH,
  parameter int         ROW_PITCH    = missile_pool_pkg::ROW_PITCH,
  parameter int         SCREEN_H     = missile_pool_pkg::SCREEN_H,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arst,
  input  logic                           frame,
  input  logic                           enable,
  input  logic [GRID_ROWS*GRID_COLS-1:0] invaders,
  input  logic [9:0]                     invaders_x,
  input  logic [9:0]                     invaders_y,
  input  logic [N_MISSILES-1:0]          player_collision,
  output logic [N_MISSILES-1:0]          m_active,
  output logic [10*N_MISSILES-1:0]       m_x,
  output logic [10*N_MISSILES-1:0]       m_y,
  output logic                           fire,
  output logic [1:0]                     fsm_state
);

  import missile_pool_pkg::*;

  localparam int CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int TW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

  fsm_t                  state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         miss_q, miss_d;
  logic [RW-1:0]         row_q, row_d;
  logic [TW-1:0]         timer_q;
  logic [7:0]            lfsr_val;
  logic                  spawn_req;
  logic                  col_hit;
  logic [RW-1:0]         hit_row;
  logic                  any_free;
  logic [N_MISSILES-1:0] free_onehot;
  logic [N_MISSILES-1:0] slot_load;
  logic [9:0]            spawn_x;
  logic [9:0]            spawn_y;
  logic                  unused_lfsr_hi;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (arst),
    .seed (LFSR_SEED),
    .out  (lfsr_val)
  );

  // Only the low nibble picks a column; the rest of the register is carried along.
  assign unused_lfsr_hi = ^lfsr_val[7:4];

  // Frame counter that requests a spawn once every SPAWN_FRAMES enabled frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (arst) begin
      timer_q <= '0;
    end else if (frame && enable) begin
      timer_q <= (timer_q == TW'(SPAWN_FRAMES - 1)) ? '0 : timer_q + 1'b1;
    end
  end

  assign spawn_req = frame && enable && (timer_q == TW'(SPAWN_FRAMES - 1));

  // Probe the current column: any live invader, and the lowest (largest row index) one.
  always_comb begin
    col_hit = 1'b0;
    hit_row = '0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      if (invaders[r*GRID_COLS + int'(col_q)]) begin
        col_hit = 1'b1;
        hit_row = RW'(r);
      end
    end
  end

  // Lowest-index inactive slot; a slot being cleared this cycle is still busy.
  always_comb begin
    free_onehot = '0;
    any_free    = 1'b0;
    for (int i = 0; i < N_MISSILES; i++) begin
      if (!m_active[i] && !any_free) begin
        free_onehot[i] = 1'b1;
        any_free       = 1'b1;
      end
    end
  end

  // Muzzle position under the chosen invader, using the grid origin of the spawn cycle.
  assign spawn_x = 10'(int'(invaders_x) + int'(col_q) * COL_PITCH + COL_PITCH / 2);
  assign spawn_y = 10'(int'(invaders_y) + (int'(row_q) + 1) * ROW_PITCH);

  // Spawn sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      miss_q  <= '0;
      row_q   <= '0;
    end else if (arst) begin
      state_q <= IDLE;
      col_q   <= '0;
      miss_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      miss_q  <= miss_d;
      row_q   <= row_d;
    end
  end

  // Spawn sequencer: accept a request, scan columns one per cycle, then load a slot.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    miss_d    = miss_q;
    row_d     = row_q;
    fire      = 1'b0;
    slot_load = '0;
    case (state_q)
      IDLE: begin
        if (spawn_req && any_free && (|invaders)) begin
          state_d = SEARCH;
          col_d   = CW'(lfsr_col(lfsr_val[3:0], GRID_COLS));
          miss_d  = '0;
        end
      end
      SEARCH: begin
        if (col_hit) begin
          state_d = SPAWN;
          row_d   = hit_row;
        end else if (miss_q == CW'(GRID_COLS - 1)) begin
          // Every column came up empty: the mask was cleared during the scan.
          state_d = IDLE;
        end else begin
          miss_d = miss_q + 1'b1;
          col_d  = (col_q == CW'(GRID_COLS - 1)) ? '0 : col_q + 1'b1;
        end
      end
      SPAWN: begin
        state_d = IDLE;
        if (any_free) begin
          fire      = 1'b1;
          slot_load = free_onehot;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

  for (genvar i = 0; i < N_MISSILES; i++) begin : g_slot
    logic        act_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [10:0] y_next;

    assign y_next = {1'b0, y_q} + 11'(SPEED);

    // Slot life cycle: collision beats movement; a free slot only listens for a load.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (arst) begin
        act_q <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (act_q) begin
        if (player_collision[i]) begin
          act_q <= 1'b0;
          x_q   <= '0;
          y_q   <= '0;
        end else if (frame && enable) begin
          if (y_next >= 11'(SCREEN_H)) begin
            act_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
          end else begin
            y_q <= y_next[9:0];
          end
        end
      end else if (slot_load[i]) begin
        act_q <= 1'b1;
        x_q   <= spawn_x;
        y_q   <= spawn_y;
      end
    end

    assign m_active[i]      = act_q;
    assign m_x[10*i +: 10]  = x_q;
    assign m_y[10*i +: 10]  = y_q;
  end

endmodule

// File: tb/tb_missile_pool.sv
// Self-checking bench for missile_pool: directed scenarios plus a randomized
// run, all compared every cycle against a behavioural model of the pool.
module tb_missile_pool;

  localparam int N  = 3;
  localparam int SP = 2;
  localparam int SF = 30;
  localparam int C  = 11;
  localparam int R  = 5;
  localparam int CP = 16;
  localparam int RP = 16;
  localparam int SH = 480;

  logic              clk;
  logic              rst;
  logic              arst;
  logic              frame;
  logic              enable;
  logic [R*C-1:0]    invaders;
  logic [9:0]        invaders_x;
  logic [9:0]        invaders_y;
  logic [N-1:0]      player_collision;
  logic [N-1:0]      m_active;
  logic [10*N-1:0]   m_x;
  logic [10*N-1:0]   m_y;
  logic              fire;
  logic [1:0]        fsm_state;

  missile_pool dut (
    .clk              (clk),
    .rst              (rst),
    .arst             (arst),
    .frame            (frame),
    .enable           (enable),
    .invaders         (invaders),
    .invaders_x       (invaders_x),
    .invaders_y       (invaders_y),
    .player_collision (player_collision),
    .m_active         (m_active),
    .m_x              (m_x),
    .m_y              (m_y),
    .fire             (fire),
    .fsm_state        (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots as plain integers; spawn sequencing as "phase" 0 waiting, 1 scanning, 2 placing.
  int mdl_act [N];
  int mdl_x   [N];
  int mdl_y   [N];
  int mdl_lfsr, mdl_timer, mdl_phase, mdl_col, mdl_left, mdl_row;
  int cyc, req_cyc, fire_cyc, fire_cnt;
  bit seen_fire;
  bit en_g;

  function automatic int next_lfsr(input int v);
    int nb;
    nb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | nb) & 255;
  endfunction

  function automatic int live_row(input int col);
    for (int r = R - 1; r >= 0; r--)
      if (invaders[r*C + col]) return r;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mdl_act[i] = 0;
      mdl_x[i]   = 0;
      mdl_y[i]   = 0;
    end
    mdl_lfsr  = 'hA5;
    mdl_timer = 0;
    mdl_phase = 0;
    mdl_col   = 0;
    mdl_left  = 0;
    mdl_row   = 0;
  endtask

  task automatic model_clock();
    int ff;
    int ny;
    int lr;
    bit req;
    if (arst) begin
      model_reset();
      return;
    end
    ff = -1;
    for (int i = 0; i < N; i++)
      if (mdl_act[i] == 0 && ff < 0) ff = i;
    req = frame && enable && (mdl_timer == SF - 1);
    for (int i = 0; i < N; i++) begin
      if (mdl_act[i] != 0) begin
        if (player_collision[i]) begin
          mdl_act[i] = 0; mdl_x[i] = 0; mdl_y[i] = 0;
        end else if (frame && enable) begin
          ny = mdl_y[i] + SP;
          if (ny >= SH) begin
            mdl_act[i] = 0; mdl_x[i] = 0; mdl_y[i] = 0;
          end else begin
            mdl_y[i] = ny;
          end
        end
      end else if (mdl_phase == 2 && i == ff) begin
        mdl_act[i] = 1;
        mdl_x[i]   = (int'(invaders_x) + mdl_col * CP + CP / 2) % 1024;
        mdl_y[i]   = (int'(invaders_y) + (mdl_row + 1) * RP) % 1024;
      end
    end
    case (mdl_phase)
      0: begin
        if (req && ff >= 0 && invaders != '0) begin
          mdl_phase = 1;
          mdl_col   = mdl_lfsr % 16;
          if (mdl_col >= C) mdl_col = mdl_col - C;
          mdl_left  = C;
          req_cyc   = cyc;
        end
      end
      1: begin
        lr = live_row(mdl_col);
        if (lr >= 0) begin
          mdl_row   = lr;
          mdl_phase = 2;
        end else begin
          mdl_left--;
          if (mdl_left == 0) mdl_phase = 0;
          else mdl_col = (mdl_col + 1) % C;
        end
      end
      default: mdl_phase = 0;
    endcase
    if (frame && enable) mdl_timer = (mdl_timer == SF - 1) ? 0 : mdl_timer + 1;
    mdl_lfsr = next_lfsr(mdl_lfsr);
  endtask

  task automatic compare_outputs();
    logic [N-1:0]    ea;
    logic [10*N-1:0] ex;
    logic [10*N-1:0] ey;
    logic            ef;
    for (int i = 0; i < N; i++) begin
      ea[i]          = (mdl_act[i] != 0);
      ex[10*i +: 10] = 10'(mdl_x[i]);
      ey[10*i +: 10] = 10'(mdl_y[i]);
    end
    ef = (mdl_phase == 2) && (ea != '1);
    check("fire", fire, ef);
    check("m_active", m_active, ea);
    check("m_x", m_x, ex);
    check("m_y", m_y, ey);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive on the falling edge, compare mid-low phase, then advance the model.
  task automatic cycle(input bit f, input bit en, input logic [N-1:0] c);
    @(negedge clk);
    cyc++;
    frame            = f;
    enable           = en;
    player_collision = c;
    #2;
    compare_outputs();
    if (fire === 1'b1) begin
      seen_fire = 1'b1;
      fire_cyc  = cyc;
      fire_cnt++;
    end
    @(posedge clk);
    #1;
    model_clock();
  endtask

  // Frames on every second clock keep whole spawn periods short.
  task automatic tick(input logic [N-1:0] c = '0);
    cycle((cyc % 2) == 1, en_g, c);
  endtask

  task automatic wait_fire(input string tag, input int budget);
    seen_fire = 1'b0;
    for (int k = 0; k < budget && !seen_fire; k++) tick();
    check(tag, seen_fire, 1'b1);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_async_active", m_active, '0);
    check("arst_async_x", m_x, '0);
    check("arst_async_y", m_y, '0);
    check("arst_async_fire", fire, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int              lat;
    int              fc0;
    bit              found;
    logic [10*N-1:0] snap;
    logic [63:0]     rnd;

    cyc = 0; req_cyc = 0; fire_cyc = 0; fire_cnt = 0; seen_fire = 1'b0;
    rst = 1'b0; arst = 1'b0; frame = 1'b0; enable = 1'b0; en_g = 1'b1;
    invaders = '0; invaders_x = '0; invaders_y = '0; player_collision = '0;
    model_reset();

    // Reset state.
    @(posedge clk);
    #1;
    check("reset_active", m_active, '0);
    check("reset_x", m_x, '0);
    check("reset_y", m_y, '0);
    check("reset_fire", fire, 1'b0);
    check("reset_state", fsm_state, 2'd0);
    rst = 1'b1;

    // Full grid at origin (100,50): bottom row is 4, so y = 50 + 5*16.
    invaders   = '1;
    invaders_x = 10'd100;
    invaders_y = 10'd50;
    wait_fire("spawn1_timeout", 120);
    check("spawn1_y", m_y[9:0], 10'd130);
    check("spawn1_x", m_x[9:0], 10'(100 + mdl_col * CP + CP / 2));
    wait_fire("spawn2_timeout", 100);
    check("spawn2_active", m_active, 3'b011);
    check("spawn2_y", m_y[19:10], 10'd130);

    // Asynchronous reset with two missiles in flight.
    async_reset_check();

    // Fill the pool, then a request must be dropped.
    wait_fire("fill1_timeout", 120);
    wait_fire("fill2_timeout", 100);
    wait_fire("fill3_timeout", 100);
    check("pool_full", m_active, 3'b111);
    fc0 = fire_cnt;
    repeat (70) tick();
    check("pool_full_nofire", fire_cnt - fc0, 0);
    tick(3'b010);
    check("collide_slot1", m_active, 3'b101);
    wait_fire("refill_timeout", 80);
    check("refill_active", m_active, 3'b111);
    check("refill_slot1_y", m_y[19:10], 10'd130);

    // Let slot 0 fall off the bottom of the screen.
    found = 1'b0;
    for (int k = 0; k < 800 && !found; k++) begin
      tick();
      if (m_active[0] === 1'b0) found = 1'b1;
    end
    check("retire_seen", found, 1'b1);
    check("retire_x", m_x[9:0], 10'd0);
    check("retire_y", m_y[9:0], 10'd0);

    // Restart, single live invader at column 7 row 1: column fallback scan.
    arst = 1'b1;
    tick();
    arst = 1'b0;
    invaders     = '0;
    invaders[18] = 1'b1;
    wait_fire("fallback_timeout", 120);
    lat = fire_cyc - req_cyc;
    check("fallback_latency_range", (lat >= 2 && lat <= C + 1), 1'b1);
    check("fallback_x", m_x[9:0], 10'd220);
    check("fallback_y", m_y[9:0], 10'd82);

    // Collision on slot 0 together with a frame while the sequencer is placing.
    found = 1'b0;
    for (int k = 0; k < 120 && !found; k++) begin
      if (mdl_phase == 2) begin
        cycle(1'b1, 1'b1, 3'b001);
        found = 1'b1;
      end else begin
        tick();
      end
    end
    check("simul_reached", found, 1'b1);
    check("simul_active", m_active, 3'b010);
    check("simul_new_y", m_y[19:10], 10'd82);
    check("simul_new_x", m_x[19:10], 10'd220);

    // Frozen play field: positions must hold across ten frames.
    en_g = 1'b0;
    for (int i = 0; i < N; i++) snap[10*i +: 10] = 10'(mdl_y[i]);
    repeat (20) tick();
    check("freeze_hold_y", m_y, snap);
    en_g = 1'b1;

    // Empty grid never fires.
    invaders = '0;
    fc0 = fire_cnt;
    repeat (130) tick();
    check("empty_mask_nofire", fire_cnt - fc0, 0);

    // Randomized play against the model.
    invaders = '1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        rnd = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: invaders = '0;
          1: begin invaders = '0; invaders[$urandom_range(0, R*C-1)] = 1'b1; end
          default: invaders = rnd[R*C-1:0];
        endcase
      end
      if ($urandom_range(0, 99) == 0) begin
        invaders_x = 10'($urandom_range(0, 1023));
        invaders_y = 10'($urandom_range(0, 420));
      end
      arst = ($urandom_range(0, 999) == 0);
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
            ($urandom_range(0, 19) == 0) ? N'(1 << $urandom_range(0, N - 1)) : N'(0));
      arst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
